// File: rtl/parking_system.sv
// Car-park entrance gate: entrance sensor opens a password window, a correct code opens the gate.
// LEDs lag the state by one cycle, HEX digits decode the state directly; no handshake, no backpressure.
module parking_system #(
  parameter int         WAIT_CYCLES = 4,
  parameter logic [1:0] PASS_1      = 2'b01,
  parameter logic [1:0] PASS_2      = 2'b10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             pass_ok;
  logic             wait_done;

  assign pass_ok   = (password_1 == PASS_1) && (password_2 == PASS_2);
  assign wait_done = (wait_cnt == CNT_LAST);

  // reset_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (reset_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Counter only runs inside the password window and clears on the edge that leaves it
  always_ff @(posedge clk) begin
    if (reset_n || (state != WAIT_PASSWORD) || wait_done) wait_cnt <= '0;
    else                                                   wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:          state_nxt = sensor_entrance ? WAIT_PASSWORD : IDLE;
      WAIT_PASSWORD: begin
        if (wait_done) state_nxt = pass_ok ? RIGHT_PASS : WRONG_PASS;
        else           state_nxt = WAIT_PASSWORD;
      end
      WRONG_PASS:    state_nxt = pass_ok ? RIGHT_PASS : WRONG_PASS;
      RIGHT_PASS: begin
        if (sensor_entrance && sensor_exit) state_nxt = STOP;
        else if (sensor_exit)               state_nxt = IDLE;
        else                                state_nxt = RIGHT_PASS;
      end
      STOP:          state_nxt = (sensor_entrance && pass_ok) ? RIGHT_PASS : STOP;
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
    end else begin
      case (state)
        WAIT_PASSWORD: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b1;
        end
        RIGHT_PASS: begin
          GREEN_LED <= ~GREEN_LED;
          RED_LED   <= 1'b0;
        end
        WRONG_PASS, STOP: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= ~RED_LED;
        end
        default: begin
          GREEN_LED <= 1'b0;
          RED_LED   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    HEX_1 = SEG_BLANK;
    HEX_2 = SEG_BLANK;
    case (state)
      WAIT_PASSWORD: begin HEX_1 = SEG_E; HEX_2 = SEG_N; end
      WRONG_PASS:    begin HEX_1 = SEG_E; HEX_2 = SEG_E; end
      RIGHT_PASS:    begin HEX_1 = SEG_G; HEX_2 = SEG_O; end
      STOP:          begin HEX_1 = SEG_S; HEX_2 = SEG_P; end
      default:       begin HEX_1 = SEG_BLANK; HEX_2 = SEG_BLANK; end
    endcase
  end

endmodule

// File: tb/tb_parking_system.sv
// Directed stimulus for the parking gate; expected outputs per edge go to a scoreboard drained by a monitor.
module tb_parking_system;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SN = 7'b0101011;
  localparam logic [6:0] SG = 7'b0000010;
  localparam logic [6:0] SO = 7'b1000000;
  localparam logic [6:0] SS = 7'b0010010;
  localparam logic [6:0] SP = 7'b0001100;

  typedef struct packed {
    logic       g;
    logic       r;
    logic [6:0] h1;
    logic [6:0] h2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  parking_system dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic g, input logic r, input logic [6:0] h1, input logic [6:0] h2);
    exp_t e;
    e.g  = g;
    e.r  = r;
    e.h1 = h1;
    e.h2 = h2;
    return e;
  endfunction

  // Drive one cycle of inputs, then queue the outputs expected after the next rising edge
  task automatic cyc(input logic rst, input logic ent, input logic ext,
                     input logic [1:0] p1, input logic [1:0] p2,
                     input exp_t e, input string nm);
    reset_n         = rst;
    sensor_entrance = ent;
    sensor_exit     = ext;
    password_1      = p1;
    password_2      = p2;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {GREEN_LED, RED_LED, HEX_1, HEX_2};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL %s: got g=%0b r=%0b hex1=%h hex2=%h, want g=%0b r=%0b hex1=%h hex2=%h",
                   nm, got.g, got.r, got.h1, got.h2, e.g, e.r, e.h1, e.h2);
        end
      end
    end
  end

  initial begin : stimulus
    int drain;
    // Reset held 5 cycles with the entrance sensor active
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 2'b01, 2'b10, mk(0, 0, BL, BL), "reset_idle");

    // Correct code: 4-cycle window, then GO with green blinking
    cyc(0, 1, 0, 2'b01, 2'b10, mk(0, 0, SE, SN), "enter_wait");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "wait_cnt1");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "wait_cnt2");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "wait_cnt3");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SG, SO), "right_pass");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(1, 0, SG, SO), "green_on");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 0, SG, SO), "green_off");
    // Exit alone: HEX blank at once, green still lags one cycle
    cyc(0, 0, 1, 2'b01, 2'b10, mk(1, 0, BL, BL), "exit_idle_lag");
    cyc(0, 0, 1, 2'b01, 2'b10, mk(0, 0, BL, BL), "idle_ignores_exit");

    // Wrong code: EE with red blinking, then correct code recovers
    cyc(0, 1, 0, 2'b00, 2'b00, mk(0, 0, SE, SN), "wrong_enter_wait");
    cyc(0, 0, 0, 2'b00, 2'b00, mk(0, 1, SE, SN), "wrong_wait1");
    cyc(0, 0, 0, 2'b00, 2'b00, mk(0, 1, SE, SN), "wrong_wait2");
    cyc(0, 0, 0, 2'b00, 2'b00, mk(0, 1, SE, SN), "wrong_wait3");
    cyc(0, 0, 0, 2'b00, 2'b00, mk(0, 1, SE, SE), "wrong_pass");
    cyc(0, 0, 0, 2'b00, 2'b00, mk(0, 0, SE, SE), "red_off");
    cyc(0, 0, 0, 2'b01, 2'b00, mk(0, 1, SE, SE), "red_on_half_code");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 0, SG, SO), "wrong_to_right");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(1, 0, SG, SO), "right_green");

    // Tailgating: STOP, red blinks, only entrance plus correct code releases it
    cyc(0, 1, 1, 2'b01, 2'b10, mk(0, 0, SS, SP), "tailgate_stop");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SS, SP), "stop_no_entrance");
    cyc(0, 1, 0, 2'b00, 2'b00, mk(0, 0, SS, SP), "stop_bad_code");
    cyc(0, 1, 0, 2'b01, 2'b10, mk(0, 1, SG, SO), "stop_to_right");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(1, 0, SG, SO), "right_again");
    cyc(0, 0, 1, 2'b01, 2'b10, mk(0, 0, BL, BL), "exit_again");

    // Reset mid-window at wait_cnt=2, then a full fresh window
    cyc(0, 1, 0, 2'b01, 2'b10, mk(0, 0, SE, SN), "win2_enter");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "win2_cnt1");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "win2_cnt2");
    cyc(1, 1, 0, 2'b01, 2'b10, mk(0, 0, BL, BL), "mid_wait_reset");
    cyc(0, 1, 0, 2'b01, 2'b10, mk(0, 0, SE, SN), "win3_enter");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "win3_cnt1");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "win3_cnt2");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SE, SN), "win3_cnt3");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(0, 1, SG, SO), "win3_right");
    cyc(0, 0, 0, 2'b01, 2'b10, mk(1, 0, SG, SO), "win3_green");
    // Reset while green is lit clears LEDs on the same edge
    cyc(1, 0, 0, 2'b01, 2'b10, mk(0, 0, BL, BL), "reset_in_right");

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
